// File: rtl/uart_tx_arbiter_if.sv
// Bundles the two FIFO read ports and the uart transmitter handshake.
// Latency: none, this is wiring only.
// Backpressure: none here; the arbiter paces the FIFOs through tx_done.
interface uart_tx_arbiter_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  empty0;
   logic [DATA_WIDTH-1:0] rd_data0;
   logic                  rd_en0;
   logic                  empty1;
   logic [DATA_WIDTH-1:0] rd_data1;
   logic                  rd_en1;
   logic                  tx_start;
   logic [DATA_WIDTH-1:0] tx_data;
   logic                  tx_done;
   logic                  busy;
   logic                  grant;
   logic                  timeout_err;

   // Arbiter side
   modport master (
      input  empty0, rd_data0, empty1, rd_data1, tx_done,
      output rd_en0, rd_en1, tx_start, tx_data, busy, grant, timeout_err
   );

   // FIFO / transmitter side
   modport slave (
      output empty0, rd_data0, empty1, rd_data1, tx_done,
      input  rd_en0, rd_en1, tx_start, tx_data, busy, grant, timeout_err
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one uart transmitter between the echo FIFO (0) and status FIFO (1).
// Latency: pop + tx_start one cycle after a non-empty FIFO is sampled; one idle cycle between bytes.
// Backpressure: holds in WAIT until tx_done or the timeout, so at most one byte is in flight.
module uart_tx_arbiter #(
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 200000,
   parameter int CNT_WIDTH      = 18
) (
   input  logic               clk,
   input  logic               reset,
   uart_tx_arbiter_if.master  bus
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;

   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

   // Reject parameter sets the counter cannot represent
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("uart_tx_arbiter: TIMEOUT_CYCLES must be at least 2");
   end
   if ((64'(1) << CNT_WIDTH) <= 64'(TIMEOUT_CYCLES)) begin : g_bad_cnt
      $error("uart_tx_arbiter: CNT_WIDTH too small for TIMEOUT_CYCLES");
   end

   logic [0:0]            state_q,       state_d;
   logic                  rd_en0_q,      rd_en0_d;
   logic                  rd_en1_q,      rd_en1_d;
   logic                  tx_start_q,    tx_start_d;
   logic [DATA_WIDTH-1:0] tx_data_q,     tx_data_d;
   logic                  busy_q,        busy_d;
   logic                  grant_q,       grant_d;
   logic                  timeout_err_q, timeout_err_d;
   logic [CNT_WIDTH-1:0]  cnt_q,         cnt_d;

   logic any_req;
   logic winner;

   // Pick the requester: a lone non-empty FIFO wins, a tie goes to the one not served last
   always_comb begin
      any_req = ~bus.empty0 | ~bus.empty1;
      winner  = 1'b0;
      if (~bus.empty0 & ~bus.empty1) begin
         winner = ~grant_q;
      end else begin
         winner = bus.empty0;
      end
   end

   // Next-state: grant from IDLE, then wait for done or timeout
   always_comb begin
      state_d       = state_q;
      rd_en0_d      = 1'b0;
      rd_en1_d      = 1'b0;
      tx_start_d    = 1'b0;
      timeout_err_d = 1'b0;
      tx_data_d     = tx_data_q;
      busy_d        = busy_q;
      grant_d       = grant_q;
      cnt_d         = cnt_q;
      case (state_q)
         ST_IDLE: begin
            // tx_done is meaningless here and deliberately not looked at
            if (any_req) begin
               rd_en0_d   = ~winner;
               rd_en1_d   = winner;
               tx_start_d = 1'b1;
               tx_data_d  = winner ? bus.rd_data1 : bus.rd_data0;
               grant_d    = winner;
               cnt_d      = '0;
               busy_d     = 1'b1;
               state_d    = ST_WAIT;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q + CNT_ONE;
            // A done seen in the start cycle cannot belong to this byte.
            // Done wins over a timeout on the same edge.
            if (bus.tx_done && !tx_start_q) begin
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               busy_d        = 1'b0;
               timeout_err_d = 1'b1;
               state_d       = ST_IDLE;
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; grant resets to 1 so requester 0 wins the first tie
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         rd_en0_q      <= 1'b0;
         rd_en1_q      <= 1'b0;
         tx_start_q    <= 1'b0;
         tx_data_q     <= '0;
         busy_q        <= 1'b0;
         grant_q       <= 1'b1;
         timeout_err_q <= 1'b0;
         cnt_q         <= '0;
      end else begin
         state_q       <= state_d;
         rd_en0_q      <= rd_en0_d;
         rd_en1_q      <= rd_en1_d;
         tx_start_q    <= tx_start_d;
         tx_data_q     <= tx_data_d;
         busy_q        <= busy_d;
         grant_q       <= grant_d;
         timeout_err_q <= timeout_err_d;
         cnt_q         <= cnt_d;
      end
   end

   assign bus.rd_en0      = rd_en0_q;
   assign bus.rd_en1      = rd_en1_q;
   assign bus.tx_start    = tx_start_q;
   assign bus.tx_data     = tx_data_q;
   assign bus.busy        = busy_q;
   assign bus.grant       = grant_q;
   assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: FIFO and uart models around the DUT, a transaction-level
// reference checked every cycle, and directed scenarios with literal expectations.
// Runs with a short timeout so the timeout paths are reachable.
module tb_uart_tx_arbiter;
   localparam int DW = 8;
   localparam int TO = 16;
   localparam int CW = 5;

   typedef logic [DW-1:0] byte_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   uart_tx_arbiter_if #(.DATA_WIDTH(DW)) bus ();

   uart_tx_arbiter #(
      .DATA_WIDTH    (DW),
      .TIMEOUT_CYCLES(TO),
      .CNT_WIDTH     (CW)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // FIFO contents and observation log
   byte_t q0[$];
   byte_t q1[$];
   byte_t tx_log[$];
   int    n_starts = 0, n_pops = 0, n_busy = 0, n_terr = 0;
   int    cyc = 0, start_cyc = 0, terr_cyc = 0;
   int    done_delay = 0;
   int    dcnt = 0;

   // FWFT FIFO read side, refreshed away from the sampling edge
   initial begin
      bus.empty0 = 1'b1; bus.rd_data0 = '0;
      bus.empty1 = 1'b1; bus.rd_data1 = '0;
      forever begin
         @(negedge clk);
         bus.empty0   = (q0.size() == 0);
         bus.rd_data0 = (q0.size() > 0) ? q0[0] : '0;
         bus.empty1   = (q1.size() == 0);
         bus.rd_data1 = (q1.size() > 0) ? q1[0] : '0;
      end
   end

   // FIFOs pop on the edge that samples rd_en
   initial begin
      forever begin
         @(posedge clk);
         if (reset) begin
            if (bus.rd_en0 && q0.size() > 0) void'(q0.pop_front());
            if (bus.rd_en1 && q1.size() > 0) void'(q1.pop_front());
         end
      end
   end

   // Uart model: done sampled done_delay edges after the start edge (0 = never)
   initial begin
      bus.tx_done = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset) dcnt = 0;
         else if (bus.tx_start) dcnt = 1;
         else if (dcnt > 0) dcnt++;
         bus.tx_done = (done_delay > 0) && (dcnt == done_delay);
         if (bus.tx_done) dcnt = 0;
      end
   end

   // Reference: one byte outstanding at a time, aged in edges since its start
   logic  e_rd0 = 0, e_rd1 = 0, e_start = 0, e_busy = 0, e_terr = 0, e_grant = 1;
   byte_t e_data = '0;
   bit    m_active = 0;
   int    m_age = 0;
   logic  w;
   initial begin
      forever begin
         @(posedge clk or negedge reset);
         if (!reset) begin
            m_active = 0; m_age = 0;
            e_rd0 = 0; e_rd1 = 0; e_start = 0; e_busy = 0; e_terr = 0;
            e_grant = 1; e_data = '0;
         end else begin
            e_rd0 = 0; e_rd1 = 0; e_start = 0; e_terr = 0;
            if (!m_active) begin
               if (!bus.empty0 || !bus.empty1) begin
                  w        = (!bus.empty0 && !bus.empty1) ? !e_grant : bus.empty0;
                  e_rd0    = !w;
                  e_rd1    = w;
                  e_start  = 1;
                  e_grant  = w;
                  e_data   = w ? bus.rd_data1 : bus.rd_data0;
                  m_active = 1;
                  m_age    = 0;
               end
            end else begin
               m_age++;
               if (bus.tx_done && m_age >= 2) begin
                  m_active = 0;
               end else if (m_age == TO) begin
                  m_active = 0;
                  e_terr   = 1;
               end
            end
            e_busy = m_active;
         end
      end
   end

   // Per-cycle compare against the reference, plus event bookkeeping
   initial begin
      forever begin
         @(negedge clk);
         cyc++;
         chk("rd_en0",      bus.rd_en0,      e_rd0);
         chk("rd_en1",      bus.rd_en1,      e_rd1);
         chk("tx_start",    bus.tx_start,    e_start);
         chk("tx_data",     bus.tx_data,     e_data);
         chk("busy",        bus.busy,        e_busy);
         chk("grant",       bus.grant,       e_grant);
         chk("timeout_err", bus.timeout_err, e_terr);
         chk("rd_en_excl",  bus.rd_en0 & bus.rd_en1, 0);
         if (bus.tx_start === 1'b1) begin
            tx_log.push_back(bus.tx_data);
            n_starts++;
            start_cyc = cyc;
         end
         if (bus.rd_en0 === 1'b1 || bus.rd_en1 === 1'b1) n_pops++;
         if (bus.busy === 1'b1) n_busy++;
         if (bus.timeout_err === 1'b1) begin
            n_terr++;
            terr_cyc = cyc;
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_starts(input int target, input int budget, input string nm);
      int i = 0;
      while (n_starts < target && i < budget) begin
         tick();
         i++;
      end
      chk({nm, "_start_seen"}, (n_starts >= target), 1);
   endtask

   task automatic wait_idle(input int budget, input string nm);
      int i = 0;
      while (bus.busy !== 1'b0 && i < budget) begin
         tick();
         i++;
      end
      chk({nm, "_idle_seen"}, bus.busy, 0);
   endtask

   task automatic pulse_reset();
      tick();
      #1 reset = 1'b0;
      tick();
      #1 reset = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish");
      $fatal(1);
   end

   initial begin : main
      int    b_busy, b_pops, b_terr, b_start, b_log;
      byte_t exp3 [6];
      exp3 = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22};

      // Reset, then 100 quiet cycles with both FIFOs empty
      repeat (3) tick();
      #1 reset = 1'b1;
      repeat (100) tick();
      chk("idle_starts", n_starts, 0);
      chk("idle_busy",   n_busy,   0);
      chk("idle_grant",  bus.grant, 1);

      // Single byte from FIFO0, done 10 cycles after start
      done_delay = 10;
      b_busy = n_busy; b_pops = n_pops;
      q0.push_back(8'h41);
      wait_starts(1, 50, "t2");
      wait_idle(50, "t2");
      repeat (3) tick();
      chk("t2_data",  tx_log[0], 8'h41);
      chk("t2_busy",  n_busy - b_busy, 10);
      chk("t2_pops",  n_pops - b_pops, 1);
      chk("t2_grant", bus.grant, 0);

      // Both FIFOs loaded after a fresh reset: strict alternation starting at 0
      pulse_reset();
      done_delay = 5;
      b_pops = n_pops; b_start = n_starts; b_log = tx_log.size();
      for (int i = 0; i < 3; i++) begin
         q0.push_back(byte_t'(8'h10 + i));
         q1.push_back(byte_t'(8'h20 + i));
      end
      wait_starts(b_start + 6, 200, "t3");
      wait_idle(50, "t3");
      repeat (5) tick();
      for (int i = 0; i < 6; i++) chk("t3_order", tx_log[b_log + i], exp3[i]);
      chk("t3_pops",   n_pops - b_pops, 6);
      chk("t3_starts", n_starts - b_start, 6);

      // No done at all: timeout fires 16 cycles after start, then service resumes
      done_delay = 0;
      b_terr = n_terr; b_busy = n_busy; b_start = n_starts;
      q1.push_back(8'h55);
      wait_starts(b_start + 1, 20, "t4");
      begin
         int i = 0;
         while (n_terr == b_terr && i < 40) begin
            tick();
            i++;
         end
      end
      chk("t4_terr_cnt",  n_terr - b_terr, 1);
      chk("t4_terr_dist", terr_cyc - start_cyc, 16);
      chk("t4_busy",      n_busy - b_busy, 16);
      tick();
      chk("t4_back_idle", bus.busy, 0);
      done_delay = 3;
      q0.push_back(8'h66);
      wait_starts(b_start + 2, 20, "t4b");
      wait_idle(20, "t4b");
      chk("t4_next_data",  tx_log[tx_log.size() - 1], 8'h66);
      chk("t4_next_grant", bus.grant, 0);

      // Done and timeout on the same edge: done wins
      done_delay = 16;
      b_terr = n_terr; b_busy = n_busy; b_start = n_starts;
      q0.push_back(8'h77);
      wait_starts(b_start + 1, 20, "t5");
      wait_idle(40, "t5");
      repeat (3) tick();
      chk("t5_no_terr", n_terr - b_terr, 0);
      chk("t5_busy",    n_busy - b_busy, 16);
      chk("t5_data",    tx_log[tx_log.size() - 1], 8'h77);

      // Reset in the middle of WAIT with FIFO0 still holding a byte
      done_delay = 0;
      b_pops = n_pops; b_start = n_starts;
      q0.push_back(8'hA1);
      q0.push_back(8'hA2);
      wait_starts(b_start + 1, 20, "t6");
      repeat (3) tick();
      chk("t6_busy_before", bus.busy, 1);
      #1 reset = 1'b0;
      #1;
      chk("t6_rst_rd_en0",  bus.rd_en0, 0);
      chk("t6_rst_rd_en1",  bus.rd_en1, 0);
      chk("t6_rst_start",   bus.tx_start, 0);
      chk("t6_rst_busy",    bus.busy, 0);
      chk("t6_rst_grant",   bus.grant, 1);
      chk("t6_rst_data",    bus.tx_data, 0);
      chk("t6_rst_terr",    bus.timeout_err, 0);
      tick();
      #1 reset = 1'b1;
      done_delay = 4;
      wait_starts(b_start + 2, 20, "t6b");
      wait_idle(20, "t6b");
      repeat (5) tick();
      chk("t6_next_data", tx_log[tx_log.size() - 1], 8'hA2);
      chk("t6_pops",      n_pops - b_pops, 2);
      chk("t6_fifo_left", q0.size(), 0);
      chk("t6_starts",    n_starts - b_start, 2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between two byte sources: the RX echo FIFO (requester 0) and the watch status-report FIFO (requester 1).
- Pops one byte at a time from a non-empty source FIFO using round-robin arbitration, launches the transmitter, and waits for its done pulse before granting again.
- Sits between the two FIFOs' read side and the uart start/tx_data/o_tx_done interface.
- Recovers from a missing done pulse via a timeout.

Parameters:
- DATA_WIDTH, 8: byte width of FIFO data and tx_data.
- TIMEOUT_CYCLES, 200000: maximum cycles in WAIT before abandoning the byte; must be ≥ 2.
- CNT_WIDTH, 18: width of the timeout counter; must satisfy 2^CNT_WIDTH > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- empty0  input  1  requester 0 FIFO empty.
- rd_data0  input  DATA_WIDTH  requester 0 FIFO head byte; first-word fall-through, valid whenever empty0=0.
- rd_en0  output  1  one-cycle pop pulse to requester 0 FIFO.
- empty1  input  1  requester 1 FIFO empty.
- rd_data1  input  DATA_WIDTH  requester 1 FIFO head byte; FWFT.
- rd_en1  output  1  one-cycle pop pulse to requester 1 FIFO.
- tx_start  output  1  one-cycle start pulse to the uart transmitter.
- tx_data  output  DATA_WIDTH  byte to transmit; held stable from tx_start until the arbiter leaves WAIT.
- tx_done  input  1  one-cycle done pulse from the uart transmitter.
- busy  output  1  high while in WAIT.
- grant  output  1  index of the requester last granted.
- timeout_err  output  1  one-cycle pulse when a WAIT timeout fires.

Behaviour:
- Reset values (reset=0, asynchronous): state=IDLE; rd_en0, rd_en1, tx_start, busy, timeout_err = 0; tx_data = 0; grant = 1 (so requester 0 wins the first tie); timeout counter = 0.
- All outputs are registered.
- States: IDLE, WAIT.
- IDLE, at an edge, if either empty0=0 or empty1=0:
  - Winner selection: if only one requester is non-empty, it wins. If both are non-empty, the winner is ~grant (round robin).
  - Registered updates at that edge: rd_en<winner>=1, tx_start=1, tx_data<=rd_data<winner>, grant<=winner, counter<=0, state<=WAIT.
  - Latency: non-empty sampled at edge k gives rd_en and tx_start high during the cycle k to k+1, a single cycle only.
- IDLE with both FIFOs empty: stay in IDLE; all pulses 0.
- WAIT:
  - rd_en0, rd_en1 and tx_start are 0; busy=1; counter increments by 1 each cycle.
  - tx_done=1 sampled: state<=IDLE, busy<=0. The next grant occurs no earlier than the following edge, so there is 1 idle cycle between bytes.
  - counter reaches TIMEOUT_CYCLES-1 without tx_done: timeout_err=1 for one cycle, state<=IDLE. The byte is lost (it was already popped).
  - tx_done and timeout on the same edge: treat as done; timeout_err stays 0.
- tx_done in IDLE is ignored.
- tx_done is never honoured in the same cycle as tx_start. The uart asserts done at least 1 cycle after start.
- Exactly one pop per transmitted byte. rd_en0 and rd_en1 are never high together.
- Fairness: with both FIFOs continuously non-empty, grants alternate 0,1,0,1...
- A FIFO that empties while the other requester is in service is simply skipped at the next IDLE decision.
- Reset mid-WAIT: immediate return to the reset values. A byte in flight is abandoned with no pop or start replay.
- tx_data retains its last value in IDLE. It changes only at a grant.

Test Plan:
- Reset release with both FIFOs empty -> 100 cycles with rd_en0=rd_en1=tx_start=0, busy=0, grant=1.
- FIFO0 holds 0x41, tx_done pulsed 10 cycles after tx_start -> rd_en0 and tx_start pulse together once, tx_data=0x41 held through WAIT, busy high 10 cycles, grant=0.
- Both FIFOs hold 3 bytes (0x10..0x12 and 0x20..0x22), done 5 cycles after each start -> tx_data order 0x10,0x20,0x11,0x21,0x12,0x22; six pops total; no simultaneous rd_en.
- TIMEOUT_CYCLES=16, FIFO1 holds 0x55, tx_done never asserted -> timeout_err pulses once exactly 16 cycles after tx_start; state returns to IDLE; next byte is granted normally.
- tx_done and the timeout on the same edge -> timeout_err stays 0; IDLE entered.
- reset driven to 0 for 1 cycle in mid-WAIT with FIFO0 still non-empty -> all outputs at reset values immediately; after release, requester 0 is granted and only one additional pop occurs.
